tdm_mux: RTL and testbench
==========================

Name: tdm_mux

Overview:
- Parametrised, registered N-to-1 multiplexer. Generalises the 4-to-1 mux family in data width and channel count.
- Adds a manual mode, in which S selects the channel, and an automatic time-division scan mode with a programmable dwell time.
- Used as the front end for multiplexed displays and serial sampling of several buses.
- One clock domain. All outputs are registered.

Parameters:
- WIDTH, 8: data width of each channel, in bits; must be >= 1.
- CHANNELS, 4: number of input channels; must be >= 2.
- DWELL, 4: clock cycles spent on each channel in scan mode; must be >= 1.
- SEL_W, $clog2(CHANNELS): width of the selector and channel index; derived, never overridden.

Ports:
- Clock  in  1  rising-edge clock
- Resetn  in  1  asynchronous, active-low reset
- W  in  CHANNELS*WIDTH  packed channel data; channel k occupies W[k*WIDTH +: WIDTH]
- S  in  SEL_W  manual channel select
- Mode  in  1  0 = MANUAL, 1 = SCAN; sampled every clock
- Hold  in  1  in SCAN, freezes the dwell counter and the channel pointer; ignored in MANUAL
- f  out  WIDTH  selected channel data, registered
- Chan  out  SEL_W  index of the channel currently driving f
- Strobe  out  1  one-cycle pulse on the first cycle f presents a newly selected channel
- Wrap  out  1  one-cycle pulse when the scan pointer wraps back to a lower index

Behaviour:
- Interface (already decided): one clock, Clock. Resetn is asynchronous and active-low, named Resetn.
- Reset (Resetn = 0, asynchronous): f = 0, Chan = 0, Strobe = 0, Wrap = 0, dwell counter = 0, state = MANUAL.
- State machine: two states, MANUAL and SCAN. At each edge the next state equals Mode.
- MANUAL:
  - Chan <= S and f <= W[S], with 1-cycle latency from S/W to f.
  - If S >= CHANNELS (non-power-of-two counts), Chan clamps to CHANNELS-1.
  - Dwell counter is held at 0. Wrap = 0.
  - Strobe = 1 on the edge where the new Chan differs from the old Chan.
- SCAN:
  - f <= W[Chan] on every edge, so channel data is tracked live while dwelling.
  - Dwell counter runs 0 .. DWELL-1.
  - On the edge where the counter equals DWELL-1 and Hold = 0: counter <= 0 and Chan <= Chan+1, wrapping from CHANNELS-1 to 0. On that edge f <= W[new Chan], so no stale sample appears.
  - Strobe = 1 for one cycle on each advance.
  - Wrap = 1 for one cycle on the advance from CHANNELS-1 to 0.
  - DWELL = 1: Chan advances on every edge.
- Hold = 1 in SCAN: counter and Chan are frozen, f keeps tracking W[Chan], Strobe = 0 and Wrap = 0. When Hold is released, counting resumes from the frozen count.
- MANUAL -> SCAN: the pointer starts from the current Chan and the counter starts at 0. No Strobe is generated on the switch itself.
- SCAN -> MANUAL mid-dwell: the counter clears; Chan <= S on that same edge; Strobe follows the MANUAL rule.
- Strobe and Wrap are never asserted in the same cycle unless the cycle is a scan wrap, in which case both are 1.
- Reset mid-scan aborts immediately. Operation resumes in MANUAL on channel 0.

Optional Feature:
- Macro: TDM_MUX_MASK_EN.
- Defined:
  - Adds input port Mask, width CHANNELS; bit k = 1 enables channel k.
  - A scan advance goes to the next enabled index above Chan, searching with wrap-around.
  - Wrap pulses whenever the new index is <= the old index.
  - If only the current channel is enabled, the pointer stays put: no Strobe and no Wrap.
  - If Mask = 0: f <= 0, Chan holds, and Strobe and Wrap stay 0.
  - In MANUAL, selecting a masked channel gives f <= 0 while Chan still follows S.
- Undefined: no Mask port; all channels behave as enabled.

Test Plan (CHANNELS=4, WIDTH=8, DWELL=3, W = {8'hD3, 8'hC2, 8'hB1, 8'hA0}):
- Resetn = 0 pulsed mid-cycle -> f = 0, Chan = 0, Strobe = 0 and Wrap = 0 immediately, with no clock edge.
- MANUAL, S stepped 0, 1, 2, 3 one per cycle -> f = A0, B1, C2, D3 one cycle later; Strobe = 1 on each change; Strobe = 0 while S is held at 3.
- SCAN from Chan = 0 for 12 cycles -> Chan = 0,0,0,1,1,1,2,2,2,3,3,3 and f tracks accordingly; Wrap = 1 exactly on the cycle Chan goes 3 -> 0.
- SCAN with Hold = 1 for 5 cycles at Chan = 2, count 1 -> Chan stays 2 and Strobe = 0; after release, advance to 3 after 2 more cycles.
- SCAN -> MANUAL at count 1 with S = 1 -> next edge Chan = 1, f = B1, Strobe = 1; counter cleared, which re-entering SCAN confirms with a full 3-cycle dwell.
- TDM_MUX_MASK_EN defined, Mask = 4'b1010, SCAN -> Chan = 1, 3, 1, 3 with Wrap on each 3 -> 1; Mask = 0 -> f = 0 with Chan held.

Source files
------------

// File: rtl/tdm_mux_if.sv
// rtl/tdm_mux_if.sv - channel data, control and output bundle for tdm_mux
// Optional feature macro: TDM_MUX_MASK_EN (adds Mask, one enable bit per channel)
// Signals:
//   W      - packed channel data, channel k at W[k*WIDTH +: WIDTH]
//   S      - manual channel select
//   Mode   - 0 = MANUAL, 1 = SCAN
//   Hold   - freezes the scan pointer and dwell counter in SCAN
//   Mask   - channel enables (TDM_MUX_MASK_EN only)
//   f      - registered selected data
//   Chan   - index of the channel driving f
//   Strobe - one-cycle pulse when f presents a newly selected channel
//   Wrap   - one-cycle pulse when the scan pointer wraps to a lower index
// Modports: master drives inputs (bench side), slave is the mux side.
interface tdm_mux_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] W;
  logic [SEL_W-1:0]          S;
  logic                      Mode;
  logic                      Hold;
`ifdef TDM_MUX_MASK_EN
  logic [CHANNELS-1:0]       Mask;
`endif
  logic [WIDTH-1:0]          f;
  logic [SEL_W-1:0]          Chan;
  logic                      Strobe;
  logic                      Wrap;

`ifdef TDM_MUX_MASK_EN
  modport master (output W, S, Mode, Hold, Mask, input f, Chan, Strobe, Wrap);
  modport slave  (input W, S, Mode, Hold, Mask, output f, Chan, Strobe, Wrap);
`else
  modport master (output W, S, Mode, Hold, input f, Chan, Strobe, Wrap);
  modport slave  (input W, S, Mode, Hold, output f, Chan, Strobe, Wrap);
`endif
endinterface

// File: rtl/tdm_mux.sv
// rtl/tdm_mux.sv - registered N-to-1 mux with manual select and timed scan
// Optional feature macro: TDM_MUX_MASK_EN (per-channel enables on bus.Mask)
// Ports:
//   Clock  - rising-edge clock
//   Resetn - asynchronous active-low reset
//   bus    - tdm_mux_if.slave: W, S, Mode, Hold, [Mask] in; f, Chan, Strobe, Wrap out
module tdm_mux #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4
) (
  input  logic     Clock,
  input  logic     Resetn,
  tdm_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);

  typedef enum logic {MANUAL = 1'b0, SCAN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0] chan_q, chan_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             strobe_q, strobe_d;
  logic             wrap_q, wrap_d;

  logic [WIDTH-1:0]    ch_data [CHANNELS];
  logic [CHANNELS-1:0] en;
  logic [SEL_W-1:0]    s_sel;
  logic [SEL_W-1:0]    adv_idx;
  logic                adv_ok;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_unpack
    assign ch_data[k] = bus.W[k*WIDTH +: WIDTH];
  end

`ifdef TDM_MUX_MASK_EN
  assign en = bus.Mask;
`else
  assign en = '1;
`endif

  // Out-of-range selects (non-power-of-two channel counts) land on the last channel.
  assign s_sel = (bus.S > LAST_CH) ? LAST_CH : bus.S;

  function automatic logic [SEL_W-1:0] ch_add(input logic [SEL_W-1:0] base, input int ofs);
    return SEL_W'((int'(base) + ofs) % CHANNELS);
  endfunction

  // Next enabled channel above chan_q with wrap-around. Scanning offsets from
  // high to low lets the nearest enabled channel win. The current channel
  // itself is never a candidate, so a lone enabled channel yields adv_ok = 0.
  always_comb begin
    adv_idx = chan_q;
    adv_ok  = 1'b0;
    for (int i = CHANNELS - 1; i >= 1; i--) begin
      if (en[ch_add(chan_q, i)]) begin
        adv_idx = ch_add(chan_q, i);
        adv_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = bus.Mode ? SCAN : MANUAL;
    cnt_d    = '0;
    chan_d   = chan_q;
    strobe_d = 1'b0;
    wrap_d   = 1'b0;
    if (!bus.Mode) begin
      chan_d   = s_sel;
      strobe_d = (s_sel != chan_q);
    end else if (state_q == MANUAL) begin
      // Entry edge into SCAN: keep the current channel and start a fresh dwell.
      cnt_d = '0;
    end else if (bus.Hold) begin
      cnt_d = cnt_q;
    end else if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
      if (adv_ok) begin
        chan_d   = adv_idx;
        strobe_d = 1'b1;
        wrap_d   = (adv_idx <= chan_q);
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // f follows the channel being registered this edge, so an advance never shows a stale sample.
    f_d = en[chan_d] ? ch_data[chan_d] : '0;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= MANUAL;
      cnt_q    <= '0;
      chan_q   <= '0;
      f_q      <= '0;
      strobe_q <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chan_q   <= chan_d;
      f_q      <= f_d;
      strobe_q <= strobe_d;
      wrap_q   <= wrap_d;
    end
  end

  assign bus.f      = f_q;
  assign bus.Chan   = chan_q;
  assign bus.Strobe = strobe_q;
  assign bus.Wrap   = wrap_q;
endmodule

// File: tb/tb_tdm_mux.sv
// tb/tb_tdm_mux.sv - directed self-checking bench for tdm_mux
module tb_tdm_mux;
  localparam int WIDTH    = 8;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 3;

  logic Clock = 1'b0;
  logic Resetn;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [7:0] chv [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

  // Hand-computed scan sequence from Chan = 0, DWELL = 3; index 0 is the entry edge.
  int scan_chan   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int scan_strobe [13] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
  int scan_wrap   [13] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  tdm_mux_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

  tdm_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DWELL(DWELL)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] ef, input logic [1:0] ec,
                            input logic es, input logic ew);
    check({tag, ".f"}, 32'(bus.f), 32'(ef));
    check({tag, ".chan"}, 32'(bus.Chan), 32'(ec));
    check({tag, ".strobe"}, 32'(bus.Strobe), 32'(es));
    check({tag, ".wrap"}, 32'(bus.Wrap), 32'(ew));
  endtask

  initial begin
    Resetn   = 1'b0;
    bus.W    = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    bus.S    = 2'd0;
    bus.Mode = 1'b0;
    bus.Hold = 1'b0;
`ifdef TDM_MUX_MASK_EN
    bus.Mask = 4'b1111;
`endif
    #12;
    expect_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
    Resetn = 1'b1;
    step();

    // Load a non-zero state, then pulse reset between edges.
    bus.S = 2'd3;
    step();
    expect_out("pre_rst", 8'hD3, 2'd3, 1'b1, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    expect_out("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    Resetn = 1'b1;

    // MANUAL stepping
    bus.S = 2'd0;
    step();
    expect_out("man_s0", 8'hA0, 2'd0, 1'b0, 1'b0);
    for (int s = 1; s < 4; s++) begin
      bus.S = 2'(s);
      step();
      expect_out($sformatf("man_s%0d", s), chv[s], 2'(s), 1'b1, 1'b0);
    end
    step();
    expect_out("man_hold3", 8'hD3, 2'd3, 1'b0, 1'b0);
    bus.S = 2'd0;
    step();
    expect_out("man_back0", 8'hA0, 2'd0, 1'b1, 1'b0);

    // SCAN from channel 0
    bus.Mode = 1'b1;
    for (int i = 0; i < 13; i++) begin
      step();
      expect_out($sformatf("scan[%0d]", i), chv[scan_chan[i]], 2'(scan_chan[i]),
                 1'(scan_strobe[i]), 1'(scan_wrap[i]));
    end

    // Reach Chan = 2 with count 1, then hold while channel 2 data changes.
    for (int i = 0; i < 7; i++) step();
    check("pre_hold.chan", 32'(bus.Chan), 32'd2);
    bus.Hold = 1'b1;
    bus.W[23:16] = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      step();
      expect_out($sformatf("hold[%0d]", i), 8'h5A, 2'd2, 1'b0, 1'b0);
    end
    bus.W[23:16] = 8'hC2;
    bus.Hold = 1'b0;
    step();
    expect_out("rel1", 8'hC2, 2'd2, 1'b0, 1'b0);
    step();
    expect_out("rel2", 8'hD3, 2'd3, 1'b1, 1'b0);

    // SCAN -> MANUAL at count 1
    step();
    bus.Mode = 1'b0;
    bus.S = 2'd1;
    step();
    expect_out("to_man", 8'hB1, 2'd1, 1'b1, 1'b0);
    bus.Mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("reentry[%0d]", i), 8'hB1, 2'd1, 1'b0, 1'b0);
    end
    step();
    expect_out("reentry_adv", 8'hC2, 2'd2, 1'b1, 1'b0);

    // Reset mid-scan
    #2;
    Resetn = 1'b0;
    #1;
    expect_out("scan_rst", 8'h00, 2'd0, 1'b0, 1'b0);
    Resetn = 1'b1;
    bus.Mode = 1'b0;
    bus.S = 2'd0;
    step();
    expect_out("post_rst", 8'hA0, 2'd0, 1'b0, 1'b0);

`ifdef TDM_MUX_MASK_EN
    begin
      int mchan [4] = '{1, 3, 1, 3};
      int mwrap [4] = '{0, 0, 1, 0};
      bus.Mask = 4'b1010;
      step();
      expect_out("mask_man0", 8'h00, 2'd0, 1'b0, 1'b0);
      bus.Mode = 1'b1;
      step();
      expect_out("mask_entry", 8'h00, 2'd0, 1'b0, 1'b0);
      for (int a = 0; a < 4; a++) begin
        step();
        step();
        step();
        expect_out($sformatf("mask_adv%0d", a), chv[mchan[a]], 2'(mchan[a]), 1'b1, 1'(mwrap[a]));
      end
      bus.Mask = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        step();
        expect_out($sformatf("mask_zero[%0d]", i), 8'h00, 2'd3, 1'b0, 1'b0);
      end
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
